// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
package uart_program_loader_pkg;

  typedef enum logic [1:0] {
    LEN,
    DATA,
    DONE,
    ERROR
  } loader_state_t;

  localparam int unsigned UART_DATA_BITS   = 8;
  localparam int unsigned LOADER_LEN_BYTES = 4;

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, one-cycle byte/framing-error pulses.
module uart_rx
  import uart_program_loader_pkg::UART_DATA_BITS;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rx_i,
  output logic                      rx_valid_o,
  output logic [UART_DATA_BITS-1:0] rx_data_o,
  output logic                      rx_frame_err_o
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half    = CLKS_PER_BIT / 2;
  localparam int unsigned BitIdxW = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  rx_state_t                 state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [BitIdxW-1:0]        bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      valid_q, valid_d;
  logic                      err_q, err_d;
  logic                      sync1_q, sync2_q, prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = START;
          // The edge is seen one cycle late, so count from 1 to land on mid-bit.
          cnt_d   = CntW'(1);
        end
      end
      START: begin
        if (cnt_q == CntW'(Half - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shift_d   = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BitIdxW'(1);
          if (bit_idx_q == BitIdxW'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          err_d   = !sync2_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign rx_valid_o     = valid_q;
  assign rx_data_o      = shift_q;
  assign rx_frame_err_o = err_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed image over UART, writes it to program memory,
// and holds the CPU in reset until the image has been fully and correctly loaded.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MEM_WORDS    = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rx,
  output logic        mem_write_enable,
  output logic [31:0] mem_byte_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error
);

  logic                      rx_valid;
  logic                      rx_frame_err;
  logic [UART_DATA_BITS-1:0] rx_data;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .rx_i          (io_rx),
    .rx_valid_o    (rx_valid),
    .rx_data_o     (rx_data),
    .rx_frame_err_o(rx_frame_err)
  );

  loader_state_t state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;
  logic [31:0]   len_q, len_d;
  logic [31:0]   k_q, k_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   word_full;
  logic          last_byte;

  // Little-endian: each new byte enters at the top and earlier bytes shift down.
  assign word_full = {rx_data, word_q[31:8]};
  assign last_byte = (byte_idx_q == 2'(LOADER_LEN_BYTES - 1));

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    len_d      = len_q;
    k_d        = k_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      LEN: begin
        if (rx_frame_err) begin
          state_d = ERROR;
        end else if (rx_valid) begin
          word_d     = word_full;
          byte_idx_d = byte_idx_q + 2'd1;
          if (last_byte) begin
            len_d = word_full;
            if (word_full == 32'd0) begin
              state_d = DONE;
            end else if (word_full > 32'(MEM_WORDS)) begin
              state_d = ERROR;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (rx_frame_err) begin
          state_d = ERROR;
        end else if (k_q == len_q) begin
          // Reached one cycle after the final strobe, so release lags the write.
          state_d = DONE;
        end else if (rx_valid) begin
          word_d     = word_full;
          byte_idx_d = byte_idx_q + 2'd1;
          if (last_byte) begin
            we_d    = 1'b1;
            addr_d  = k_q << 2;
            wdata_d = word_full;
            k_d     = k_q + 32'd1;
          end
        end
      end
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LEN;
      byte_idx_q <= '0;
      word_q     <= '0;
      len_q      <= '0;
      k_q        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      len_q      <= len_d;
      k_q        <= k_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign mem_write_enable = we_q;
  assign mem_byte_address = addr_q;
  assign mem_write_data   = wdata_q;
  assign load_done        = (state_q == DONE);
  assign cpu_reset_n      = (state_q == DONE);
  assign load_error       = (state_q == ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed and randomized image loads against an image-level model of the loader.
module tb_uart_program_loader;

  localparam int unsigned CPB = 4;
  localparam int unsigned MW  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_rx = 1'b1;
  logic        mem_write_enable;
  logic [31:0] mem_byte_address;
  logic [31:0] mem_write_data;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .MEM_WORDS   (MW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .io_rx           (io_rx),
    .mem_write_enable(mem_write_enable),
    .mem_byte_address(mem_byte_address),
    .mem_write_data  (mem_write_data),
    .cpu_reset_n     (cpu_reset_n),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and release monitor; scenarios compare against snapshots of these.
  logic [31:0] st_addr[$];
  logic [31:0] st_data[$];
  int unsigned st_cyc[$];
  int unsigned dbl = 0;
  int unsigned done_cyc = 0;
  int unsigned done_rises = 0;
  logic        we_prev = 1'b0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_write_enable) begin
      st_addr.push_back(mem_byte_address);
      st_data.push_back(mem_write_data);
      st_cyc.push_back(cyc);
      if (we_prev) dbl <= dbl + 1;
    end
    we_prev <= mem_write_enable;
    if (load_done && !done_prev) begin
      done_cyc   <= cyc;
      done_rises <= done_rises + 1;
    end
    done_prev <= load_done;
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] img[16];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".we"}, {31'd0, mem_write_enable}, 32'd0);
    check({tag, ".addr"}, mem_byte_address, 32'd0);
    check({tag, ".data"}, mem_write_data, 32'd0);
    check({tag, ".cpu_rst_n"}, {31'd0, cpu_reset_n}, 32'd0);
    check({tag, ".done"}, {31'd0, load_done}, 32'd0);
    check({tag, ".error"}, {31'd0, load_error}, 32'd0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
    io_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    io_rx = stop;
    repeat (CPB) @(negedge clk);
    io_rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, gap);
  endtask

  task automatic do_reset();
    io_rx   = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Sends a length word and payload, then checks the outcome the image format dictates.
  task automatic run_load(input logic [31:0] n, input int gap, input bit rnd, input string tag);
    int          base;
    int          drc;
    int          dbl0;
    int          nsend;
    bit          exp_err;
    int          nw;
    base    = st_addr.size();
    drc     = done_rises;
    dbl0    = dbl;
    exp_err = (n > MW);
    nsend   = exp_err ? 2 : int'(n);
    if (rnd) for (int i = 0; i < 16; i++) img[i] = $urandom;
    send_word(n, gap);
    for (int i = 0; i < nsend; i++) send_word(img[i], gap);
    repeat (30) @(negedge clk);
    nw = st_addr.size() - base;
    check({tag, ".nwrites"}, nw, exp_err ? 32'd0 : n);
    if (!exp_err) begin
      for (int k = 0; k < int'(n) && k < nw; k++) begin
        check($sformatf("%s.addr%0d", tag, k), st_addr[base+k], 32'(k * 4));
        check($sformatf("%s.data%0d", tag, k), st_data[base+k], img[k]);
      end
    end
    check({tag, ".done"}, {31'd0, load_done}, {31'd0, !exp_err});
    check({tag, ".cpu_rst_n"}, {31'd0, cpu_reset_n}, {31'd0, !exp_err});
    check({tag, ".error"}, {31'd0, load_error}, {31'd0, exp_err});
    check({tag, ".done_rises"}, done_rises - drc, exp_err ? 32'd0 : 32'd1);
    check({tag, ".single_cycle_we"}, dbl - dbl0, 32'd0);
    if (!exp_err && n != 0 && nw > 0) begin
      check({tag, ".release_lat"}, done_cyc, st_cyc[st_cyc.size()-1] + 1);
      check({tag, ".addr_hold"}, mem_byte_address, (n - 1) << 2);
      check({tag, ".data_hold"}, mem_write_data, img[n-1]);
    end
  endtask

  int base;

  initial begin
    @(negedge clk);
    check_reset_vals("in_reset");
    do_reset();
    check_reset_vals("after_reset");

    // Basic load
    img[0] = 32'h1234_5678;
    img[1] = 32'hDEAD_BEEF;
    run_load(32'd2, 3, 1'b0, "basic");

    // Empty image, then trailing bytes must be ignored
    do_reset();
    run_load(32'd0, 2, 1'b1, "empty");
    base = st_addr.size();
    send_byte(8'h11, 1'b1, 1);
    send_byte(8'h22, 1'b1, 1);
    send_byte(8'h33, 1'b1, 1);
    send_byte(8'h44, 1'b1, 1);
    repeat (20) @(negedge clk);
    check("empty.trailing_writes", st_addr.size() - base, 32'd0);
    check("empty.still_done", {31'd0, load_done}, 32'd1);

    // Oversize: spec value and a random large count with the MSB set
    do_reset();
    run_load(32'd5, 1, 1'b1, "oversize5");
    do_reset();
    run_load(32'h8000_0000 | 32'($urandom), 1, 1'b1, "oversize_big");

    // Framing error after two data bytes
    do_reset();
    base = st_addr.size();
    send_word(32'd1, 1);
    send_byte(8'hA1, 1'b1, 1);
    send_byte(8'hB2, 1'b1, 1);
    send_byte(8'hC3, 1'b0, 4);
    repeat (20) @(negedge clk);
    check("frame.error", {31'd0, load_error}, 32'd1);
    check("frame.cpu_rst_n", {31'd0, cpu_reset_n}, 32'd0);
    send_word(32'h0102_0304, 1);
    repeat (20) @(negedge clk);
    check("frame.nwrites", st_addr.size() - base, 32'd0);
    check("frame.done", {31'd0, load_done}, 32'd0);

    // One-cycle glitch must not produce a byte
    do_reset();
    io_rx = 1'b0;
    @(negedge clk);
    io_rx = 1'b1;
    repeat (12) @(negedge clk);
    run_load(32'd1, 2, 1'b1, "glitch");

    // Mid-load reset clears everything at once, reload restarts at address 0
    do_reset();
    send_word(32'd1, 1);
    send_byte(8'h5A, 1'b1, 1);
    send_byte(8'hA5, 1'b1, 1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    img[0] = 32'hDDCC_BBAA;
    run_load(32'd1, 1, 1'b0, "reload");

    // Back-to-back frames, full memory
    do_reset();
    run_load(32'd4, 0, 1'b1, "b2b");

    // Randomized in-range loads
    for (int t = 0; t < 3; t++) begin
      do_reset();
      run_load(32'($urandom_range(MW, 1)), int'($urandom_range(3, 0)), 1'b1,
               $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Boot-time loader that receives a program image over the serial line `io_rx` (8N1, LSB first) and writes it word by word into instruction memory through the program-memory write port. It sits upstream of the CPU's fetch path, drives the program-memory address, write-enable and write-data inputs, and holds the CPU core in reset until the image is complete. The core is released only after a successful load; a malformed image leaves it in reset.

## Interface
- `CLKS_PER_BIT`, default 434: clocks per UART bit (50 MHz / 115200); must be ≥ 4.
- `MEM_WORDS`, default 256: capacity of program memory in 32-bit words.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `io_rx` in 1: serial input, idle high, asynchronous to `clk`.
- `mem_write_enable` out 1: one-cycle write strobe to program memory.
- `mem_byte_address` out 32: byte address of the write, always word-aligned.
- `mem_write_data` out 32: word to write.
- `cpu_reset_n` out 1: active-low reset to the CPU core, low until the load completes.
- `load_done` out 1: image loaded, sticky.
- `load_error` out 1: image rejected, sticky.

## Operation
- Image format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian. Word k is written to byte address 4k.
- Receiver:
  - Two-flop synchronizer on `io_rx`; both flops reset to 1.
  - Start is detected only on a high→low edge of the synchronized line.
  - Start bit is re-checked at mid-bit (CLKS_PER_BIT/2). If the line is high there, it was a glitch: return to idle with no byte.
  - 8 data bits are then sampled at CLKS_PER_BIT intervals, followed by the stop bit.
  - Stop bit = 1: `rx_valid` pulses one cycle with the byte.
  - Stop bit = 0: `rx_frame_err` pulses one cycle.
- Loader FSM states: LEN, DATA, DONE, ERROR. Reset state is LEN.
- LEN: collect 4 bytes into N, with a 2-bit byte index wrapping 3→0. On the 4th byte:
  - N == 0 → DONE.
  - N > MEM_WORDS → ERROR.
  - otherwise → DATA.
- DATA: shift bytes into the word assembler. On the 4th byte, issue a write for word index k, then k++. After the write of word N-1 → DONE.
- DONE: `load_done`=1 and `cpu_reset_n`=1. Further bytes are ignored and cause no writes.
- ERROR: `load_error`=1 and `cpu_reset_n` stays 0. No writes. Only `reset_n` exits this state.
- Framing error in LEN or DATA → ERROR. A partial word is discarded.
- Asserting `reset_n` mid-load clears all state immediately. A reload always restarts at LEN and overwrites memory from address 0.

## Timing
- Reset values: `mem_write_enable`=0, `mem_byte_address`=0, `mem_write_data`=0, `cpu_reset_n`=0, `load_done`=0, `load_error`=0.
- `io_rx` to synchronized line: 2 cycles.
- `rx_valid` asserts 1 cycle after the stop-bit mid-sample.
- Write strobe:
  - `mem_write_enable` is high for exactly 1 cycle, in the cycle after `rx_valid` of byte 3 of a word.
  - Address and data are registered and stable in that same cycle.
  - Address and data hold their values after the strobe.
- Release: `load_done` and `cpu_reset_n` rise together, 1 cycle after the final write strobe. For N=0 they rise 1 cycle after the 4th length byte.
- `load_error` rises 1 cycle after the offending `rx_valid` or `rx_frame_err`.
- Word counter is 32 bits wide, and N is compared as unsigned 32-bit. The address is k<<2.
- Back-to-back frames with no idle gap between stop bit and next start are supported.

## Structure
- Add to `common` package:
  - `loader_state_t` enum {LEN, DATA, DONE, ERROR}.
  - `UART_DATA_BITS` = 8.
  - `LOADER_LEN_BYTES` = 4.
- Sub-module `uart_rx` contains the synchronizer, bit-timing counter, shift register, and `rx_valid`/`rx_data`/`rx_frame_err` outputs. Receiver states: IDLE, START, DATA, STOP.
- The loader FSM, byte index, word assembler and word counter live in `uart_program_loader`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and MEM_WORDS=4.

- Basic load. Send N=2 (02 00 00 00), then 78 56 34 12, then EF BE AD DE.
  - Two strobes: addr 0 with data 0x12345678, then addr 4 with data 0xDEADBEEF.
  - `cpu_reset_n` and `load_done` rise 1 cycle after the second strobe.
- Empty image. Send N=0.
  - No strobes; `load_done`=1.
  - Extra bytes 11 22 33 44 sent afterwards produce no strobe.
- Oversize image. Send N=5.
  - `load_error`=1, `cpu_reset_n`=0.
  - Following data produces no strobes.
- Framing error. Send N=1, then 2 data bytes, then a byte with stop bit 0.
  - `load_error`=1 and no strobe.
- Glitch and mid-load reset:
  - A 1-cycle low pulse on `io_rx` produces no byte.
  - Pulse `reset_n` low after 2 data bytes: all outputs return to reset values immediately.
  - A full resend of N=1, AA BB CC DD then writes 0xDDCCBBAA to address 0.
- Back-to-back frames. Send N=4 with 16 data bytes and zero idle gap between frames.
  - Four strobes at addresses 0, 4, 8, C with the correct words.
